array_order_check: RTL and testbench

- Parametrised successor to the single-mode sortedness checker.
- Scans LENGTH consecutive words of a synchronous-read memory, starting at BASE, and checks them against a selectable ordering (ascending/descending, strict/non-strict, signed/unsigned).
- Reports pass/fail, the index of the first violating element, an optional total inversion count, and a range error.
- Sits between a register-file/RAM read port and the top-level control that drives the go/done handshake.

---
 rtl/array_check_pkg.sv | 18 +
 rtl/order_compare.sv | 39 +++
 rtl/array_order_check.sv | 186 ++++++++++++++++++
 tb/tb_array_order_check.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/array_check_pkg.sv
// rtl/array_check_pkg.sv - shared ordering-mode and scan-state encodings
package array_check_pkg;

    typedef enum logic [1:0] {
        MODE_ND = 2'b00,
        MODE_SI = 2'b01,
        MODE_NI = 2'b10,
        MODE_SD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FIRST = 2'b01,
        SCAN  = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/order_compare.sv
// rtl/order_compare.sv - flags an adjacent pair that breaks the selected ordering
module order_compare
    import array_check_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] cur,
    input  logic [1:0]        mode,
    output logic              violation
);

    logic gt;
    logic lt;

    always_comb begin
        if (SIGNED != 0) begin
            gt = $signed(prev) > $signed(cur);
            lt = $signed(prev) < $signed(cur);
        end else begin
            gt = prev > cur;
            lt = prev < cur;
        end
    end

    // Strict modes reject equality, so they test the negated opposite relation.
    always_comb begin
        violation = 1'b0;
        case (mode_e'(mode))
            MODE_ND: violation = gt;
            MODE_SI: violation = !lt;
            MODE_NI: violation = lt;
            MODE_SD: violation = !gt;
            default: violation = 1'b0;
        endcase
    end

endmodule

// File: rtl/array_order_check.sv
// rtl/array_order_check.sv - scans a memory range and checks it against an ordering
module array_order_check
    import array_check_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 32,
    parameter int  SIGNED = 0,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  length,
    input  logic [1:0]        mode,
    input  logic              count_all,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              sorted,
    output logic              range_error,
    output logic [LEN_W-1:0]  first_inv_idx,
    output logic [LEN_W-1:0]  inv_count
);

    localparam logic [LEN_W:0] DEPTH_X = (LEN_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          mode_q, mode_d;
    logic                count_all_q, count_all_d;
    logic                skip_q, skip_d;
    logic [LEN_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                sorted_q, sorted_d;
    logic                range_q, range_d;
    logic [LEN_W-1:0]    first_q, first_d;
    logic [LEN_W-1:0]    inv_q, inv_d;

    logic                violation;
    logic [LEN_W:0]      end_x;
    logic                more;
    logic                last;
    logic                exit_early;

    order_compare #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .prev      (prev_q),
        .cur       (rd_data),
        .mode      (mode_q),
        .violation (violation)
    );

    assign end_x      = {{(LEN_W + 1 - ADDR_W){1'b0}}, base} + {1'b0, length};
    assign more       = ({1'b0, k_q} + (LEN_W + 1)'(1)) < {1'b0, len_q};
    assign last       = k_q == (len_q - LEN_W'(1));
    assign exit_early = (k_q != '0) && violation && !count_all_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        mode_d      = mode_q;
        count_all_d = count_all_q;
        skip_d      = skip_q;
        k_d         = k_q;
        prev_d      = prev_q;
        sorted_d    = sorted_q;
        range_d     = range_q;
        first_d     = first_q;
        inv_d       = inv_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    base_d      = base;
                    len_d       = length;
                    mode_d      = mode;
                    count_all_d = count_all;
                    k_d         = '0;
                    prev_d      = '0;
                    first_d     = '0;
                    inv_d       = '0;
                    range_d     = 1'b0;
                    sorted_d    = 1'b1;
                    skip_d      = 1'b0;
                    state_d     = FIRST;
                    // Trivial outcomes still pass through FIRST (with no read) so done lands one edge after accept.
                    if (end_x > DEPTH_X) begin
                        range_d  = 1'b1;
                        sorted_d = 1'b0;
                        skip_d   = 1'b1;
                    end else if (length <= LEN_W'(1)) begin
                        skip_d = 1'b1;
                    end
                end
            end
            FIRST: begin
                if (!skip_q) begin
                    rd_en   = 1'b1;
                    rd_addr = base_q;
                end
                k_d     = '0;
                state_d = skip_q ? DONE : SCAN;
            end
            SCAN: begin
                // No read is issued for an element that will never be compared.
                if (more && !exit_early) begin
                    rd_en   = 1'b1;
                    rd_addr = base_q + k_q[ADDR_W-1:0] + ADDR_W'(1);
                end
                if (k_q == '0) begin
                    prev_d = rd_data;
                    k_d    = LEN_W'(1);
                end else begin
                    if (violation) begin
                        sorted_d = 1'b0;
                        if (inv_q != '1) begin
                            inv_d = inv_q + LEN_W'(1);
                        end
                        if (sorted_q) begin
                            first_d = k_q;
                        end
                    end
                    if (exit_early || last) begin
                        state_d = DONE;
                    end else begin
                        prev_d = rd_data;
                        k_d    = k_q + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (!go) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            mode_q      <= '0;
            count_all_q <= 1'b0;
            skip_q      <= 1'b0;
            k_q         <= '0;
            prev_q      <= '0;
            sorted_q    <= 1'b0;
            range_q     <= 1'b0;
            first_q     <= '0;
            inv_q       <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            count_all_q <= count_all_d;
            skip_q      <= skip_d;
            k_q         <= k_d;
            prev_q      <= prev_d;
            sorted_q    <= sorted_d;
            range_q     <= range_d;
            first_q     <= first_d;
            inv_q       <= inv_d;
        end
    end

    assign sorted        = sorted_q;
    assign range_error   = range_q;
    assign first_inv_idx = first_q;
    assign inv_count     = inv_q;

endmodule

// File: tb/tb_array_order_check.sv
// tb/tb_array_order_check.sv - directed bench for array_order_check
module tb_array_order_check;
    import array_check_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        go_u, go_s;
    logic [4:0]  base;
    logic [5:0]  length;
    logic [1:0]  mode;
    logic        count_all;

    logic        rd_en_u, rd_en_s, done_u, done_s, sorted_u, sorted_s, rerr_u, rerr_s;
    logic [4:0]  rd_addr_u, rd_addr_s;
    logic [31:0] rd_data_u, rd_data_s;
    logic [5:0]  first_u, first_s, inv_u, inv_s;

    logic [31:0] mem [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sel      = 1'b0;
    int          lat, reads;

    logic        done_x, rd_en_x, sorted_x, rerr_x;
    logic [5:0]  first_x, inv_x;

    always #5 clock = ~clock;

    array_order_check #(.DATA_W(32), .DEPTH(32), .SIGNED(0)) u_dut (
        .clock(clock), .reset(reset), .go(go_u), .base(base), .length(length),
        .mode(mode), .count_all(count_all), .rd_en(rd_en_u), .rd_addr(rd_addr_u),
        .rd_data(rd_data_u), .done(done_u), .sorted(sorted_u), .range_error(rerr_u),
        .first_inv_idx(first_u), .inv_count(inv_u)
    );

    array_order_check #(.DATA_W(32), .DEPTH(32), .SIGNED(1)) u_dut_s (
        .clock(clock), .reset(reset), .go(go_s), .base(base), .length(length),
        .mode(mode), .count_all(count_all), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
        .rd_data(rd_data_s), .done(done_s), .sorted(sorted_s), .range_error(rerr_s),
        .first_inv_idx(first_s), .inv_count(inv_s)
    );

    always_ff @(posedge clock) begin
        if (rd_en_u) rd_data_u <= mem[rd_addr_u];
        if (rd_en_s) rd_data_s <= mem[rd_addr_s];
    end

    assign done_x   = sel ? done_s   : done_u;
    assign rd_en_x  = sel ? rd_en_s  : rd_en_u;
    assign sorted_x = sel ? sorted_s : sorted_u;
    assign rerr_x   = sel ? rerr_s   : rerr_u;
    assign first_x  = sel ? first_s  : first_u;
    assign inv_x    = sel ? inv_s    : inv_u;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input bit s, input logic [4:0] b, input logic [5:0] l,
                       input logic [1:0] m, input bit ca, input bit hold,
                       output int lat_o, output int reads_o);
        go_u = 1'b0;
        go_s = 1'b0;
        sel  = s;
        @(negedge clock);
        base = b; length = l; mode = m; count_all = ca;
        if (s) go_s = 1'b1; else go_u = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) begin
            go_u = 1'b0;
            go_s = 1'b0;
        end
        base = ~b; length = 6'd0; mode = ~m; count_all = ~ca;
        @(negedge clock);
        lat_o = 0;
        reads_o = 0;
        while (!done_x && lat_o < 200) begin
            if (rd_en_x) reads_o++;
            @(negedge clock);
            lat_o++;
        end
    endtask

    task automatic results(input string tag, input int el, input int er, input bit srt,
                           input bit rerr, input int fi, input int ic);
        check({tag, ".latency"}, lat, el);
        check({tag, ".reads"}, reads, er);
        check({tag, ".sorted"}, sorted_x, srt);
        check({tag, ".range_error"}, rerr_x, rerr);
        check({tag, ".first_inv_idx"}, first_x, fi);
        check({tag, ".inv_count"}, inv_x, ic);
        check({tag, ".rd_en_in_done"}, rd_en_x, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = i;
        reset = 1'b1; go_u = 1'b0; go_s = 1'b0;
        base = '0; length = '0; mode = '0; count_all = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst.done", done_u, 0);
        check("rst.sorted", sorted_u, 0);
        check("rst.rd_en", rd_en_u, 0);
        check("rst.range_error", rerr_u, 0);
        check("rst.inv_count", inv_u, 0);
        reset = 1'b0;

        run(0, 5'd11, 6'd5, MODE_ND, 0, 0, lat, reads);
        results("ramp", 6, 5, 1, 0, 0, 0);

        mem[2] = 1; mem[3] = 2; mem[4] = 3; mem[5] = 2; mem[6] = 5;
        run(0, 5'd2, 6'd5, MODE_ND, 0, 0, lat, reads);
        results("early", 5, 4, 0, 0, 3, 1);

        mem[1] = 5; mem[2] = 7; mem[3] = 1; mem[4] = 1; mem[5] = 2; mem[6] = 3;
        run(0, 5'd1, 6'd6, MODE_ND, 1, 0, lat, reads);
        results("count_nd", 7, 6, 0, 0, 2, 1);
        run(0, 5'd1, 6'd6, MODE_SI, 1, 0, lat, reads);
        results("count_si", 7, 6, 0, 0, 2, 2);

        for (int i = 1; i <= 6; i++) mem[i] = 3;
        run(0, 5'd1, 6'd6, MODE_ND, 0, 0, lat, reads);
        results("equal_nd", 7, 6, 1, 0, 0, 0);
        run(0, 5'd1, 6'd6, MODE_SD, 1, 0, lat, reads);
        results("equal_sd", 7, 6, 0, 0, 1, 5);

        mem[0] = 32'hFFFF_FFFF; mem[1] = 0; mem[2] = 2;
        run(1, 5'd0, 6'd3, MODE_SI, 0, 0, lat, reads);
        results("signed", 4, 3, 1, 0, 0, 0);
        run(0, 5'd0, 6'd3, MODE_SI, 0, 0, lat, reads);
        results("unsigned_neg", 3, 2, 0, 0, 1, 1);

        run(0, 5'd30, 6'd3, MODE_ND, 0, 0, lat, reads);
        results("range", 1, 0, 0, 1, 0, 0);
        run(0, 5'd31, 6'd1, MODE_ND, 0, 0, lat, reads);
        results("len1", 1, 0, 1, 0, 0, 0);
        run(0, 5'd0, 6'd0, MODE_SD, 0, 0, lat, reads);
        results("len0", 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < 32; i++) mem[i] = i;
        sel = 1'b0;
        @(negedge clock);
        base = 5'd0; length = 6'd8; mode = MODE_ND; count_all = 1'b0; go_u = 1'b1;
        @(posedge clock);
        #1 go_u = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort.done", done_u, 0);
        check("abort.sorted", sorted_u, 0);
        check("abort.rd_en", rd_en_u, 0);
        check("abort.rd_addr", rd_addr_u, 0);
        check("abort.inv_count", inv_u, 0);
        reset = 1'b0;
        run(0, 5'd0, 6'd8, MODE_ND, 0, 0, lat, reads);
        results("after_abort", 9, 8, 1, 0, 0, 0);

        run(0, 5'd11, 6'd5, MODE_ND, 0, 1, lat, reads);
        results("hold", 6, 5, 1, 0, 0, 0);
        repeat (3) @(negedge clock);
        check("hold.done_stays", done_u, 1);
        check("hold.no_restart_rd_en", rd_en_u, 0);
        go_u = 1'b0;
        @(negedge clock);
        check("hold.done_falls", done_u, 0);
        check("hold.sorted_kept", sorted_u, 1);
        run(0, 5'd2, 6'd5, MODE_NI, 0, 0, lat, reads);
        results("restart_ni", 3, 2, 0, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
